// File: rtl/gray_ptr_unit_pkg.sv
// Shared definitions for the Gray-coded FIFO pointer unit: side encodings
// and the pointer width helper (address bits plus one wrap bit).
package gray_ptr_unit_pkg;

  localparam int side_write_lp = 0;  // flag reports full
  localparam int side_read_lp  = 1;  // flag reports empty

  function automatic int ptr_w(input int lg_depth);
    return lg_depth + 1;
  endfunction

endpackage

// File: rtl/gray_ptr_unit_gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of the
// Gray bits at and above its position.
module gray2bin #(
  parameter int width_p = 4
) (
  input  logic [width_p-1:0] i_gray,
  output logic [width_p-1:0] o_bin
);

  // Reduction of the shifted Gray word avoids a ripple through o_bin itself.
  always_comb begin
    o_bin = '0;
    for (int i = 0; i < width_p; i++) begin
      o_bin[i] = ^(i_gray >> i);
    end
  end

endmodule

// File: rtl/gray_ptr_unit.sv
// One side of an async FIFO pointer pair: local binary/Gray pointer, registered
// conversion of the synchronised remote Gray pointer, occupancy and full/empty
// flag, plus a sticky protocol error.
module gray_ptr_unit
  import gray_ptr_unit_pkg::*;
#(
  parameter int lg_depth_p = 4,
  parameter int side_p     = side_write_lp
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic                                incr_i,
  input  logic [ptr_w(lg_depth_p)-1:0]        remote_gray_i,
  output logic [ptr_w(lg_depth_p)-1:0]        ptr_bin_o,
  output logic [ptr_w(lg_depth_p)-1:0]        ptr_gray_o,
  output logic [lg_depth_p-1:0]               addr_o,
  output logic [ptr_w(lg_depth_p)-1:0]        remote_bin_o,
  output logic [ptr_w(lg_depth_p)-1:0]        count_o,
  output logic                                flag_o,
  output logic                                err_o
);

  localparam int                  ptr_w_lp = ptr_w(lg_depth_p);
  localparam logic [ptr_w_lp-1:0] depth_lp = ptr_w_lp'(1) << lg_depth_p;

  logic [ptr_w_lp-1:0] r_ptr_bin;
  logic [ptr_w_lp-1:0] r_ptr_gray;
  logic [ptr_w_lp-1:0] r_remote_bin;
  logic                r_err;

  logic [ptr_w_lp-1:0] w_remote_bin;
  logic [ptr_w_lp-1:0] w_next_bin;
  logic [ptr_w_lp-1:0] w_count;
  logic                w_flag;
  logic                w_accept;
  logic                w_over;

  gray2bin #(
    .width_p (ptr_w_lp)
  ) u_gray2bin (
    .i_gray (remote_gray_i),
    .o_bin  (w_remote_bin)
  );

  // Occupancy is always written as "writer minus reader", so the operand
  // order flips with the side; modulo arithmetic keeps it right across wrap.
  always_comb begin
    w_count = '0;
    w_flag  = 1'b0;
    if (side_p == side_read_lp) begin
      w_count = r_remote_bin - r_ptr_bin;
      w_flag  = (w_count == '0);
    end else begin
      w_count = r_ptr_bin - r_remote_bin;
      w_flag  = (w_count >= depth_lp);
    end
  end

  assign w_over     = (w_count > depth_lp);
  assign w_accept   = incr_i & ~w_flag;
  assign w_next_bin = r_ptr_bin + {{(ptr_w_lp-1){1'b0}}, w_accept};

  // Pointer, exported Gray copy, remote conversion and sticky error all update
  // on one edge; the Gray copy is encoded from the next binary value so the
  // exported bus is a clean register output.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_ptr_bin    <= '0;
      r_ptr_gray   <= '0;
      r_remote_bin <= '0;
      r_err        <= 1'b0;
    end else begin
      r_ptr_bin    <= w_next_bin;
      r_ptr_gray   <= w_next_bin ^ (w_next_bin >> 1);
      r_remote_bin <= w_remote_bin;
      if ((incr_i & w_flag) | w_over) begin
        r_err <= 1'b1;
      end
    end
  end

  assign ptr_bin_o    = r_ptr_bin;
  assign ptr_gray_o   = r_ptr_gray;
  assign addr_o       = r_ptr_bin[lg_depth_p-1:0];
  assign remote_bin_o = r_remote_bin;
  assign count_o      = w_count;
  assign flag_o       = w_flag;
  assign err_o        = r_err;

endmodule

// File: tb/tb_gray_ptr_unit.sv
// Bench for gray_ptr_unit: a write-side and a read-side instance (depth 16)
// driven from one clock, checked against a reference model through queues.
module tb_gray_ptr_unit;

  typedef struct packed {
    logic [4:0] bin;
    logic [4:0] gray;
    logic [4:0] rbin;
    logic [4:0] count;
    logic       flag;
    logic       err;
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic       incr;
    logic [4:0] rgray;
    exp_t       exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, incr0, rst1, incr1;
  logic [4:0] rg0, rg1;
  logic [4:0] bin0, gray0, rbin0, cnt0, bin1, gray1, rbin1, cnt1;
  logic [3:0] addr0, addr1;
  logic       flag0, err0, flag1, err1;

  gray_ptr_unit #(.lg_depth_p(4), .side_p(0)) dut_w (
    .clk_i(clk), .reset_i(rst0), .incr_i(incr0), .remote_gray_i(rg0),
    .ptr_bin_o(bin0), .ptr_gray_o(gray0), .addr_o(addr0),
    .remote_bin_o(rbin0), .count_o(cnt0), .flag_o(flag0), .err_o(err0));

  gray_ptr_unit #(.lg_depth_p(4), .side_p(1)) dut_r (
    .clk_i(clk), .reset_i(rst1), .incr_i(incr1), .remote_gray_i(rg1),
    .ptr_bin_o(bin1), .ptr_gray_o(gray1), .addr_o(addr1),
    .remote_bin_o(rbin1), .count_o(cnt1), .flag_o(flag1), .err_o(err1));

  int n_checks = 0;
  int n_errors = 0;

  exp_t q0[$];
  exp_t q1[$];

  logic [4:0] m_ptr [2];
  logic [4:0] m_rem [2];
  logic       m_err [2];

  function automatic logic [4:0] b2g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [4:0] g2b(input logic [4:0] g);
    logic [4:0] b;
    b[4] = g[4];
    for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [4:0] m_count(input int s);
    return (s == 1) ? (m_rem[s] - m_ptr[s]) : (m_ptr[s] - m_rem[s]);
  endfunction

  function automatic logic m_flag(input int s);
    return (s == 1) ? (m_count(s) == 5'd0) : (m_count(s) >= 5'd16);
  endfunction

  task automatic model_step(input int s, input logic rst, input logic incr,
                            input logic [4:0] rg, output exp_t e);
    logic [4:0] c;
    logic       f;
    c = m_count(s);
    f = m_flag(s);
    if (rst) begin
      m_ptr[s] = 5'd0;
      m_rem[s] = 5'd0;
      m_err[s] = 1'b0;
    end else begin
      if (incr && !f) m_ptr[s] = m_ptr[s] + 5'd1;
      if ((incr && f) || (c > 5'd16)) m_err[s] = 1'b1;
      m_rem[s] = g2b(rg);
    end
    e.bin   = m_ptr[s];
    e.gray  = b2g(m_ptr[s]);
    e.rbin  = m_rem[s];
    e.count = m_count(s);
    e.flag  = m_flag(s);
    e.err   = m_err[s];
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cmp(input int s, input exp_t e);
    if (s == 0) begin
      check("s0_bin",   bin0,  e.bin);
      check("s0_gray",  gray0, e.gray);
      check("s0_addr",  addr0, e.bin[3:0]);
      check("s0_rbin",  rbin0, e.rbin);
      check("s0_count", cnt0,  e.count);
      check("s0_flag",  flag0, e.flag);
      check("s0_err",   err0,  e.err);
    end else begin
      check("s1_bin",   bin1,  e.bin);
      check("s1_gray",  gray1, e.gray);
      check("s1_addr",  addr1, e.bin[3:0]);
      check("s1_rbin",  rbin1, e.rbin);
      check("s1_count", cnt1,  e.count);
      check("s1_flag",  flag1, e.flag);
      check("s1_err",   err1,  e.err);
    end
  endtask

  // Inputs are applied at the falling edge, the model predicts the state after
  // the next rising edge, and the prediction is compared one falling edge later.
  task automatic tick(input bit use_tab, input exp_t tab);
    exp_t e0, e1;
    model_step(0, rst0, incr0, rg0, e0);
    model_step(1, rst1, incr1, rg1, e1);
    q0.push_back(use_tab ? tab : e0);
    q1.push_back(e1);
    @(posedge clk);
    @(negedge clk);
    cmp(0, q0.pop_front());
    cmp(1, q1.pop_front());
  endtask

  function automatic vec_t mkv(input logic rst, input logic incr, input logic [4:0] rg,
                               input logic [4:0] b, input logic [4:0] g,
                               input logic [4:0] rb, input logic [4:0] c,
                               input logic f, input logic er);
    vec_t v;
    v.rst = rst; v.incr = incr; v.rgray = rg;
    v.exp.bin = b; v.exp.gray = g; v.exp.rbin = rb;
    v.exp.count = c; v.exp.flag = f; v.exp.err = er;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab[9];
    exp_t none;
    logic [4:0] prev_g;
    none = '0;
    for (int s = 0; s < 2; s++) begin
      m_ptr[s] = 5'd0; m_rem[s] = 5'd0; m_err[s] = 1'b0;
    end

    //             rst incr rgray     bin    gray      rbin   cnt    f  e
    tab[0] = mkv(1, 1, 5'b00000, 5'd0, 5'b00000, 5'd0, 5'd0, 0, 0);
    tab[1] = mkv(0, 1, 5'b00000, 5'd1, 5'b00001, 5'd0, 5'd1, 0, 0);
    tab[2] = mkv(0, 1, 5'b00000, 5'd2, 5'b00011, 5'd0, 5'd2, 0, 0);
    tab[3] = mkv(0, 0, 5'b00001, 5'd2, 5'b00011, 5'd1, 5'd1, 0, 0);
    tab[4] = mkv(0, 1, 5'b00011, 5'd3, 5'b00010, 5'd2, 5'd1, 0, 0);
    tab[5] = mkv(0, 0, 5'b00010, 5'd3, 5'b00010, 5'd3, 5'd0, 0, 0);
    tab[6] = mkv(0, 1, 5'b00010, 5'd4, 5'b00110, 5'd3, 5'd1, 0, 0);
    tab[7] = mkv(0, 0, 5'b00110, 5'd4, 5'b00110, 5'd4, 5'd0, 0, 0);
    tab[8] = mkv(1, 1, 5'b00110, 5'd0, 5'b00000, 5'd0, 5'd0, 0, 0);

    rst0 = 1'b1; incr0 = 1'b0; rg0 = 5'd0;
    rst1 = 1'b1; incr1 = 1'b0; rg1 = 5'd0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      rst0 = tab[i].rst; incr0 = tab[i].incr; rg0 = tab[i].rgray;
      tick(1'b1, tab[i].exp);
    end

    rst0 = 1'b1; rst1 = 1'b1; incr0 = 1'b0; rg0 = 5'd0;
    tick(1'b0, none);
    check("rst_flag_w", flag0, 1'b0);
    check("rst_flag_r", flag1, 1'b1);
    rst0 = 1'b0; rst1 = 1'b0;

    // Fill the write side to full.
    incr0 = 1'b1;
    for (int i = 0; i < 16; i++) tick(1'b0, none);
    check("fill_bin",   bin0,  5'd16);
    check("fill_gray",  gray0, 5'b11000);
    check("fill_count", cnt0,  5'd16);
    check("fill_flag",  flag0, 1'b1);

    // Push while full: pointer holds, error sticks.
    tick(1'b0, none);
    check("ovf_bin", bin0, 5'd16);
    check("ovf_err", err0, 1'b1);
    incr0 = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b0, none);
    check("ovf_err_hold", err0, 1'b1);

    // Read side: remote at 4, drain four entries to empty.
    rg1 = 5'b00110;
    tick(1'b0, none);
    check("rd_rbin",  rbin1, 5'd4);
    check("rd_count", cnt1,  5'd4);
    check("rd_flag0", flag1, 1'b0);
    incr1 = 1'b1;
    for (int i = 0; i < 4; i++) tick(1'b0, none);
    check("rd_empty", flag1, 1'b1);
    check("rd_err0",  err1,  1'b0);
    incr1 = 1'b0;

    // Read side: illegal remote (24) with accepted pops, then reset wins.
    rg1 = 5'b10100;
    tick(1'b0, none);
    check("ill_r_count", cnt1, 5'd20);
    incr1 = 1'b1;
    tick(1'b0, none);
    check("ill_r_bin", bin1, 5'd5);
    check("ill_r_err", err1, 1'b1);
    rst0 = 1'b1; incr0 = 1'b1; rst1 = 1'b1;
    tick(1'b0, none);
    check("rstw_bin", bin0, 5'd0);
    check("rstw_err", err0, 1'b0);
    check("rstr_bin", bin1, 5'd0);
    check("rstr_rbin", rbin1, 5'd0);
    check("rstr_err", err1, 1'b0);
    rst0 = 1'b0; rst1 = 1'b0; incr0 = 1'b0; incr1 = 1'b0; rg1 = 5'd0;

    // Walk the write pointer to 31 with the remote trailing; one-bit Gray steps.
    incr0 = 1'b1;
    for (int i = 0; i < 31; i++) begin
      rg0 = b2g(m_ptr[0]);
      prev_g = gray0;
      tick(1'b0, none);
      check("gray_1bit", $countones(prev_g ^ gray0), 1);
    end
    incr0 = 1'b0; rg0 = 5'b10010;
    tick(1'b0, none);
    check("wrap_pre_count", cnt0, 5'd3);
    incr0 = 1'b1;
    tick(1'b0, none);
    check("wrap_bin",   bin0,  5'd0);
    check("wrap_gray",  gray0, 5'd0);
    check("wrap_count", cnt0,  5'd4);
    incr0 = 1'b0;

    // Write side: illegal remote 15 against local 0.
    rst0 = 1'b1;
    tick(1'b0, none);
    rst0 = 1'b0; rg0 = 5'b01000;
    tick(1'b0, none);
    check("ill_w_count", cnt0,  5'd17);
    check("ill_w_flag",  flag0, 1'b1);
    tick(1'b0, none);
    check("ill_w_err",   err0,  1'b1);

    // Random legal traffic on both sides.
    rst0 = 1'b1; rst1 = 1'b1;
    tick(1'b0, none);
    rst0 = 1'b0; rst1 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      incr0 = 1'($urandom_range(0, 1));
      incr1 = 1'($urandom_range(0, 1));
      rg0 = b2g(m_ptr[0] - 5'($urandom_range(0, 15)));
      rg1 = b2g(m_ptr[1] + 5'($urandom_range(1, 16)));
      tick(1'b0, none);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
